// File: rtl/seven_segment_mux_if.sv
// Display-side bundle for seven_segment_mux: digit/control inputs and scanned pin outputs.
// master drives digits and controls and watches the pins; slave is the scanner.
interface seven_segment_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    hex_mode;
  logic                    blank_lz;
  logic                    enable;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits, dp, load, hex_mode, blank_lz, enable,
    input  seg, dp_out, an, frame_start
  );

  modport slave (
    input  digits, dp, load, hex_mode, blank_lz, enable,
    output seg, dp_out, an, frame_start
  );
endinterface

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, double-buffered digit load.
// Pins are registered: a scan step seen at tick T reaches the pins at T+2; no backpressure.
module seven_segment_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  seven_segment_mux_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [6:0]    GLYPH_BLANK = 7'b1111111;

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [DW-1:0]         active_q, active_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;

  logic                  tick, boundary, upper_zero, cur_dp;
  logic [3:0]            cur_nib;
  logic [6:0]            seg_lo;
  logic [NUM_DIGITS-1:0] an_hi;

  // Glyphs in active-low form (0 = segment lit), order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
    logic [6:0] g;
    g = GLYPH_BLANK;
    case (code)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = hex ? 7'b0001000 : GLYPH_BLANK;
      4'hB: g = hex ? 7'b1100000 : GLYPH_BLANK;
      4'hC: g = hex ? 7'b0110001 : GLYPH_BLANK;
      4'hD: g = hex ? 7'b1000010 : GLYPH_BLANK;
      4'hE: g = hex ? 7'b0110000 : GLYPH_BLANK;
      4'hF: g = hex ? 7'b0111000 : GLYPH_BLANK;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  always_comb begin
    tick       = bus.enable && (presc_q == PRESC_LAST);
    boundary   = tick && (scan_q == SCAN_LAST);
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    an_hi      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_hi[i] = (SW'(i) == scan_q);
      if (SW'(i) == scan_q) begin
        cur_nib = active_q[4*i +: 4];
        cur_dp  = act_dp_q[i];
      end
      if ((SW'(i) >= scan_q) && (active_q[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end

    presc_d = presc_q;
    scan_d  = scan_q;
    if (bus.enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    end

    active_d   = active_q;
    act_dp_d   = act_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    // A load landing exactly on the boundary bypasses pending so it is not lost.
    if (boundary && bus.load) begin
      active_d   = bus.digits;
      act_dp_d   = bus.dp;
      pend_vld_d = 1'b0;
    end else begin
      if (boundary && pend_vld_q) begin
        active_d   = pend_q;
        act_dp_d   = pend_dp_q;
        pend_vld_d = 1'b0;
      end
      if (bus.load) begin
        pend_d     = bus.digits;
        pend_dp_d  = bus.dp;
        pend_vld_d = 1'b1;
      end
    end

    seg_lo   = (bus.blank_lz && (scan_q != '0) && upper_zero) ? GLYPH_BLANK
                                                             : glyph(cur_nib, bus.hex_mode);
    seg_d    = bus.enable ? (SEG_ACTIVE_LOW ? seg_lo : ~seg_lo) : SEG_OFF;
    dp_out_d = bus.enable ? (SEG_ACTIVE_LOW ? ~cur_dp : cur_dp) : SEG_ACTIVE_LOW;
    an_d     = bus.enable ? (AN_ACTIVE_LOW ? ~an_hi : an_hi)
                          : (AN_ACTIVE_LOW ? '1 : '0);
    fs_d     = bus.enable && (presc_q == '0) && (scan_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      scan_q     <= '0;
      active_q   <= '0;
      act_dp_q   <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_out_q   <= SEG_ACTIVE_LOW;
      an_q       <= AN_ACTIVE_LOW ? '1 : '0;
      fs_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      scan_q     <= scan_d;
      active_q   <= active_d;
      act_dp_q   <= act_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dp_out_q   <= dp_out_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp_out      = dp_out_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seven_segment_mux.sv
// Random-stimulus bench for seven_segment_mux against a counting reference model.
module tb_seven_segment_mux;
  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;
  localparam int CYCLES = 4000;

  logic clk = 1'b0;
  logic rst;

  seven_segment_mux_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_mux #(
    .NUM_DIGITS    (ND),
    .REFRESH_DIV   (RD),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_vec;
  int n_err;
  int cyc;

  // Model: position in the scan is just the number of enabled cycles since reset.
  int         en_cnt;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pvld;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    int d;
    logic [15:0] upper;
    logic [3:0]  nib;
    bit          boundary;
    if (rst) begin
      en_cnt = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pvld = 0;
      exp_seg = 7'h7f; exp_dp = 1'b1; exp_an = 4'hf; exp_fs = 1'b0;
      return;
    end
    if (bus.enable) begin
      d     = (en_cnt / RD) % ND;
      upper = m_act >> (4 * d);
      nib   = upper[3:0];
      if (bus.blank_lz && d > 0 && upper == 16'h0) exp_seg = 7'h7f;
      else if (nib >= 4'd10 && !bus.hex_mode)      exp_seg = 7'h7f;
      else                                          exp_seg = glyph_tab[nib];
      exp_dp = ~m_act_dp[d];
      exp_an = ~(4'b0001 << d);
      exp_fs = ((en_cnt % FRAME) == 0);
    end else begin
      exp_seg = 7'h7f; exp_dp = 1'b1; exp_an = 4'hf; exp_fs = 1'b0;
    end
    boundary = bus.enable && ((en_cnt % FRAME) == FRAME - 1);
    if (bus.load) begin
      m_pend = bus.digits; m_pend_dp = bus.dp; m_pvld = 1;
    end
    if (boundary && m_pvld) begin
      m_act = m_pend; m_act_dp = m_pend_dp; m_pvld = 0;
    end
    if (bus.enable) en_cnt++;
  endtask

  int off_left;

  task automatic drive(input int c);
    logic [15:0] dg;
    rst = (c < 3) || ($urandom_range(0, 499) == 0);
    if (off_left > 0) begin
      off_left--;
      bus.enable = 1'b0;
    end else if ($urandom_range(0, 79) == 0) begin
      off_left   = $urandom_range(3, 12);
      bus.enable = 1'b0;
    end else begin
      bus.enable = 1'b1;
    end
    if ($urandom_range(0, 39) == 0) bus.hex_mode = ~bus.hex_mode;
    if ($urandom_range(0, 39) == 0) bus.blank_lz = ~bus.blank_lz;
    for (int i = 0; i < ND; i++)
      dg[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    bus.digits = dg;
    bus.dp     = 4'($urandom_range(0, 15));
    if (bus.enable && ((en_cnt % FRAME) == FRAME - 1))
      bus.load = ($urandom_range(0, 2) == 0);
    else
      bus.load = ($urandom_range(0, 24) == 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; off_left = 0;
    en_cnt = 0; m_pvld = 0;
    rst = 1'b1;
    bus.digits = '0; bus.dp = '0; bus.load = 1'b0;
    bus.hex_mode = 1'b1; bus.blank_lz = 1'b0; bus.enable = 1'b0;
    for (int c = 0; c < CYCLES; c++) begin
      @(posedge clk);
      model_step();
      #1;
      cyc = c;
      check("seg",         32'(bus.seg),         32'(exp_seg));
      check("dp_out",      32'(bus.dp_out),      32'(exp_dp));
      check("an",          32'(bus.an),          32'(exp_an));
      check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
      drive(c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode seven-segment digits. It is the parametrised successor of the single-digit decoder and adds:
- a refresh prescaler and digit scanner;
- double-buffered (tear-free) digit loading;
- hex or decimal glyph mode, leading-zero blanking and per-digit decimal points;
- configurable output polarity.

It sits between the clock/counter logic and the board display pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2)
- SEG_ACTIVE_LOW, 1, 1: seg/dp_out low = lit; 0: high = lit
- AN_ACTIVE_LOW, 1, 1: an low = digit selected; 0: high = selected

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- digits  in  4*NUM_DIGITS  BCD/hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant
- dp  in  NUM_DIGITS  decimal point request per digit
- load  in  1  one-cycle pulse; captures digits and dp into the pending buffer
- hex_mode  in  1  1: codes 10–15 shown as A b C d E F; 0: codes 10–15 blank
- blank_lz  in  1  1: suppress leading zeros
- enable  in  1  0: display dark, scanning frozen
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0]
- dp_out  out  1  decimal point segment
- an  out  NUM_DIGITS  digit select, one-hot when active
- frame_start  out  1  one-cycle pulse when the digit-0 slot begins on the outputs

## Operation
Prescaler and scanner:
- Prescaler counts 0..REFRESH_DIV-1 while enable=1; tick = (count==REFRESH_DIV-1).
- On tick, scan_idx increments modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
- While enable=0, prescaler and scan_idx hold.

Loading (double buffer):
- load=1 writes digits/dp into pending and sets pending_valid.
- Frame boundary = tick while scan_idx==NUM_DIGITS-1. At the boundary, if pending_valid, then active<=pending and pending_valid is cleared.
- load on a boundary cycle: the just-presented digits/dp go straight to active; pending_valid ends 0.
- Repeated loads within a frame: last one wins.

Glyphs, active-low form (SEG_ACTIVE_LOW=0 inverts seg and dp_out):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- blank=1111111

Leading-zero blanking:
- Digit i (i>=1) is blanked when blank_lz=1 and active nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked.
- dp is not affected by blanking.

Other rules:
- hex_mode and blank_lz are sampled live (not buffered) at output-register update.
- an selects exactly bit scan_idx (polarity per AN_ACTIVE_LOW).
- enable=0: an, seg and dp_out all driven to the off level.

## Timing
- Reset values: prescaler=0, scan_idx=0, active=0, pending=0, pending_valid=0, frame_start=0; seg/dp_out/an at the off level (all 1 with default parameters).
- seg, dp_out, an and frame_start are registered and update every cycle from state.
- Latency: tick at cycle T -> scan_idx new at T+1 -> pins show the new digit at T+2. frame_start=1 in exactly the cycle pins first show digit 0.
- Display swap: a load is visible at the first frame_start after the next frame boundary; pins never show a mix of old and new data within one frame.
- After rst deasserts, the first digit-0 output (with frame_start) appears 1 cycle later if enable=1.
- Reset asserted mid-frame: all state takes reset values on that edge. A load in the same cycle as rst is discarded.
- enable falling: pins go dark 1 cycle later. enable rising: resume from the held scan_idx/prescaler.

## Test plan
- Setup for all: NUM_DIGITS=4, REFRESH_DIV=4, default polarities.
- rst, then enable=1 with no load -> an cycles 1110,1101,1011,0111 every 4 clks; seg=0000001 on all digits; frame_start pulses every 16 clks.
- load digits=16'h1A2F, hex_mode=1 mid-frame -> current frame unchanged; next frame shows F,2,A,1 = 0111000, 0010010, 0001000, 1001111.
- Same data with hex_mode=0 -> digits 0 and 2 show 1111111; digits 1 and 3 show 2 and 1.
- digits=16'h0070, blank_lz=1, dp=4'b0001 -> digits 3 and 2 = 1111111, digit 1 = 0001111, digit 0 = 0000001 with dp_out=0 only in the digit-0 slot.
- load on the boundary tick, then a second load 2 clks later -> first data shown next frame; second data shown the frame after.
- enable=0 for 10 clks, and separately rst mid-frame -> an=1111, seg=1111111; scan resumes at the held index; after rst, digit 0 with frame_start.
